// File: rtl/banked_mem_pkg.sv
// Shared definitions for the banked multi-port memory.
// Contents: safe_clog2() width helper, default bank-select / bank-address
// widths for the reference configuration, and the round-robin pointer type.
package banked_mem_pkg;

  // $clog2 that never yields a zero-width vector (1 for n <= 1).
  function automatic int safe_clog2(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  localparam int DefNumPorts  = 4;
  localparam int DefNumBanks  = 4;
  localparam int DefDataDepth = 4096;

  localparam int BankSelW  = safe_clog2(DefNumBanks);
  localparam int BankAddrW = safe_clog2(DefDataDepth / DefNumBanks);

  // Index of a requester port; also the width of a round-robin pointer.
  typedef logic [safe_clog2(DefNumPorts)-1:0] port_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, one grant per cycle.
// Ports: clk_i, rst_ni (async active-low); req_i request vector;
//        gnt_o one-hot grant; gnt_idx_o winning index; gnt_valid_o any grant.
// The lowest requesting index at or above the pointer wins (wrapping);
// after a grant to p the pointer moves to (p+1) mod NumReq.
module rr_arbiter
  import banked_mem_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int IdxW   = safe_clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o
);

  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] ptr_next;
  logic [IdxW-1:0] cand;

  // Scan requests starting at the pointer; first hit wins.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    ptr_next    = ptr;
    cand        = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = IdxW'((int'(ptr) + i) % NumReq);
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
        ptr_next    = (int'(cand) == NumReq - 1) ? '0 : IdxW'(int'(cand) + 1);
      end else begin
        gnt_valid_o = gnt_valid_o;
      end
    end
  end

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/single_port_memory.sv
// Single-port synchronous SRAM bank.
// Ports: clk_i clock; req_i access enable; we_i 1=write 0=read;
//        addr_i word address; wr_data_i write word;
//        rd_data_o read word, registered one cycle after a read access.
// The array and the read register are deliberately not reset.
module single_port_memory
  import banked_mem_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int DataDepth = 1024,
  parameter int AddrWidth = safe_clog2(DataDepth)
) (
  input  logic                 clk_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  output logic [DataWidth-1:0] rd_data_o
);

  logic [DataWidth-1:0] mem [DataDepth];

  // Array write and registered read, one access per cycle.
  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        mem[addr_i] <= wr_data_i;
      end else begin
        rd_data_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/banked_multi_port_memory.sv
// Multi-port memory built from NumBanks address-interleaved single-port banks.
// Ports: clk_i, rst_ni (async active-low);
//        req_i/we_i/addr_i/wr_data_i per-port request (slice p = port p);
//        gnt_o combinational per-port grant (forced low in reset);
//        rvalid_o read valid one cycle after a granted read;
//        rd_data_o per-port read word, holds its last value otherwise.
// Bank = addr mod NumBanks, bank-local address = addr / NumBanks.
module banked_multi_port_memory
  import banked_mem_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int DataDepth = 4096,
  parameter int NumPorts  = 4,
  parameter int NumBanks  = 4,
  parameter int AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts-1:0]           req_i,
  input  logic [NumPorts-1:0]           we_i,
  input  logic [NumPorts*AddrWidth-1:0] addr_i,
  input  logic [NumPorts*DataWidth-1:0] wr_data_i,
  output logic [NumPorts-1:0]           gnt_o,
  output logic [NumPorts-1:0]           rvalid_o,
  output logic [NumPorts*DataWidth-1:0] rd_data_o
);

  localparam int BankIdxW = safe_clog2(NumBanks);
  localparam int LocalW   = safe_clog2(DataDepth / NumBanks);
  localparam int PortIdxW = safe_clog2(NumPorts);

  logic [NumPorts-1:0][BankIdxW-1:0]  port_bank;
  logic [NumPorts-1:0][LocalW-1:0]    port_local;
  logic [NumPorts-1:0][DataWidth-1:0] port_wdata;
  logic [NumBanks-1:0][NumPorts-1:0]  bank_req;
  logic [NumBanks-1:0][NumPorts-1:0]  bank_gnt;
  logic [NumBanks-1:0][DataWidth-1:0] bank_rdata;
  logic [NumPorts-1:0]                gnt_any;
  logic [NumPorts-1:0][BankIdxW-1:0]  ret_bank;
  logic [NumPorts-1:0][DataWidth-1:0] held;

  // Address decode per port and steering of requests to their bank.
  always_comb begin
    port_bank  = '0;
    port_local = '0;
    port_wdata = '0;
    bank_req   = '0;
    for (int p = 0; p < NumPorts; p++) begin
      port_bank[p]  = BankIdxW'(int'(addr_i[p*AddrWidth +: AddrWidth]) % NumBanks);
      port_local[p] = LocalW'(int'(addr_i[p*AddrWidth +: AddrWidth]) / NumBanks);
      port_wdata[p] = wr_data_i[p*DataWidth +: DataWidth];
    end
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPorts; p++) begin
        bank_req[b][p] = req_i[p] & (port_bank[p] == BankIdxW'(b));
      end
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [PortIdxW-1:0] win;
    logic                won;
    logic                mem_req;

    rr_arbiter #(
      .NumReq (NumPorts),
      .IdxW   (PortIdxW)
    ) u_arb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (bank_req[b]),
      .gnt_o       (bank_gnt[b]),
      .gnt_idx_o   (win),
      .gnt_valid_o (won)
    );

    // Writes are blocked while reset is low, matching the forced-low grants.
    assign mem_req = won & rst_ni;

    single_port_memory #(
      .DataWidth (DataWidth),
      .DataDepth (DataDepth / NumBanks),
      .AddrWidth (LocalW)
    ) u_bank (
      .clk_i     (clk_i),
      .req_i     (mem_req),
      .we_i      (we_i[win]),
      .addr_i    (port_local[win]),
      .wr_data_i (port_wdata[win]),
      .rd_data_o (bank_rdata[b])
    );
  end

  // A port is granted by whichever bank it addressed.
  always_comb begin
    gnt_any = '0;
    for (int b = 0; b < NumBanks; b++) begin
      gnt_any = gnt_any | bank_gnt[b];
    end
  end

  assign gnt_o = gnt_any & {NumPorts{rst_ni}};

  // Return path: remember which bank serves each port's read; keep last word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= '0;
      ret_bank <= '0;
      held     <= '0;
    end else begin
      rvalid_o <= gnt_o & ~we_i;
      ret_bank <= port_bank;
      for (int p = 0; p < NumPorts; p++) begin
        if (rvalid_o[p]) begin
          held[p] <= bank_rdata[ret_bank[p]];
        end
      end
    end
  end

  // Live bank data in the return cycle, held copy otherwise.
  always_comb begin
    rd_data_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      rd_data_o[p*DataWidth +: DataWidth] = rvalid_o[p] ? bank_rdata[ret_bank[p]] : held[p];
    end
  end

endmodule
